ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx_pkg.sv | 24 ++
 rtl/ps2_line_sync.sv | 30 +++
 rtl/ps2_host_tx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_pkg.sv
// Shared constants, FSM state encoding and parity helper for the PS/2 host transmitter.
package ps2_host_tx_pkg;

  localparam int unsigned DEFAULT_INHIBIT_CYCLES = 5000;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 750000;

  // Data bits, parity, stop: one entry per device clock falling edge.
  localparam int unsigned FRAME_BITS = 10;

  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_INHIBIT   = 3'd1;
  localparam state_t S_REQUEST   = 3'd2;
  localparam state_t S_SEND      = 3'd3;
  localparam state_t S_ACK       = 3'd4;
  localparam state_t S_WAIT_IDLE = 3'd5;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus falling-edge detect on the synchronized value.
module ps2_line_sync (
  input  logic CLOCK_50_I,
  input  logic resetn,
  input  logic line_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Idle PS/2 lines are pulled high, so reset to 1 to avoid a false edge.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 10-bit frame, ACK and bus-idle wait.
// Define PS2_HOST_TX_ACK_CHECK_EN to turn a missing ACK on edge 11 into tx_error.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEFAULT_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       CLOCK_50_I,
  input  logic       resetn,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       PS2_CLOCK_I,
  input  logic       PS2_DATA_I,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

  logic clk_sync;
  logic clk_fall;
  logic dat_sync;
  logic dat_fall_unused;

  state_t                state_q,   state_d;
  logic [FRAME_BITS-1:0] frame_q,   frame_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0]      inh_cnt_q, inh_cnt_d;
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                  clk_oe_q,  clk_oe_d;
  logic                  dat_oe_q,  dat_oe_d;
  logic                  busy_q,    busy_d;
  logic                  done_q,    done_d;
  logic                  err_q,     err_d;

  ps2_line_sync u_clk_sync (
    .CLOCK_50_I (CLOCK_50_I),
    .resetn     (resetn),
    .line_i     (PS2_CLOCK_I),
    .sync_o     (clk_sync),
    .fall_o     (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .CLOCK_50_I (CLOCK_50_I),
    .resetn     (resetn),
    .line_i     (PS2_DATA_I),
    .sync_o     (dat_sync),
    .fall_o     (dat_fall_unused)
  );

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          frame_d   = {1'b1, odd_parity(tx_data), tx_data};
          bit_cnt_d = '0;
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          dat_oe_d  = 1'b1;
          clk_oe_d  = 1'b0;
          tmo_cnt_d = '0;
          state_d   = S_REQUEST;
        end else begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
        end
      end

      // The frame shifts out LSB first; the final shift presents the stop bit (release).
      S_REQUEST, S_SEND: begin
        if (clk_fall) begin
          dat_oe_d  = ~frame_q[0];
          frame_d   = {1'b1, frame_q[FRAME_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          state_d   = (bit_cnt_q == LAST_BIT) ? S_ACK : S_SEND;
        end
      end

      S_ACK: begin
        if (clk_fall) begin
`ifdef PS2_HOST_TX_ACK_CHECK_EN
          if (dat_sync) begin
            err_d    = 1'b1;
            busy_d   = 1'b0;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            state_d  = S_WAIT_IDLE;
          end
`else
          state_d = S_WAIT_IDLE;
`endif
        end
      end

      S_WAIT_IDLE: begin
        if (clk_sync && dat_sync) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
    endcase

    // Watchdog overrides the per-state decision so done and error can never coincide.
    if (state_q inside {S_REQUEST, S_SEND, S_ACK, S_WAIT_IDLE}) begin
      if (clk_fall) begin
        tmo_cnt_d = '0;
      end else if (tmo_cnt_q == TMO_LAST) begin
        tmo_cnt_d = '0;
        clk_oe_d  = 1'b0;
        dat_oe_d  = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b1;
        state_d   = S_IDLE;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      tmo_cnt_q <= '0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign tx_busy      = busy_q;
  assign tx_done      = done_q;
  assign tx_error     = err_q;
  assign ps2_clock_oe = clk_oe_q;
  assign ps2_data_oe  = dat_oe_q;

endmodule
